// File: rtl/ddr_bank_responder_if.sv
// Command/response bundle between the controller command path and the bank responder.
// Handshake: the master presents one command per cycle with cmd_valid (no back-pressure);
// exactly one of cmd_ack/viol pulses in the following cycle for every valid command.
interface ddr_bank_responder_if;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  bg_addr;
  logic [1:0]  ba_addr;
  logic [14:0] row_addr;
  logic        cmd_ack;
  logic        viol;
  logic [2:0]  viol_code;
  logic        rd_go;
  logic        wr_go;
  logic [3:0]  cas_bank;
  logic [14:0] cas_row;
  logic [15:0] bank_open;
  logic [31:0] dbg_bank_state;

  modport master (
    output cmd_valid, cmd, bg_addr, ba_addr, row_addr,
    input  cmd_ack, viol, viol_code, rd_go, wr_go, cas_bank, cas_row, bank_open, dbg_bank_state
  );

  modport slave (
    input  cmd_valid, cmd, bg_addr, ba_addr, row_addr,
    output cmd_ack, viol, viol_code, rd_go, wr_go, cas_bank, cas_row, bank_open, dbg_bank_state
  );
endinterface

// File: rtl/ddr_bank_responder.sv
// 16-bank DDR command responder: tracks bank state/rows and flags tRRD/tRCD/tRAS/tRP violations.
// Optional DDR_PREA_EN enables cmd 5 (PREA, precharge all); otherwise cmd 5 is reserved.
module ddr_bank_responder #(
  parameter int unsigned T_RRD = 4,
  parameter int unsigned T_RCD = 16,
  parameter int unsigned T_RAS = 39,
  parameter int unsigned T_RP  = 16
) (
  input  logic                       CK_t,
  input  logic                       reset,
  ddr_bank_responder_if.slave        bus
);
  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_e;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_PRE  = 3'd2;
  localparam logic [2:0] CMD_RD   = 3'd3;
  localparam logic [2:0] CMD_WR   = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  localparam logic [5:0] RRD_MIN  = 6'(T_RRD);
  localparam logic [5:0] RCD_LOAD = 6'(T_RCD - 1);
  localparam logic [5:0] RAS_LOAD = 6'(T_RAS - 1);
  localparam logic [5:0] RP_LOAD  = 6'(T_RP - 1);

  bank_state_e state_q [16], state_d [16];
  logic [5:0]  cnt_q   [16], cnt_d   [16];
  logic [5:0]  ras_q   [16], ras_d   [16];
  logic [14:0] row_q   [16], row_d   [16];
  logic [5:0]  rrd_q, rrd_d;
  logic        ack_q, ack_d, viol_q, viol_d, rd_q, rd_d, wr_q, wr_d;
  logic [2:0]  code_q, code_d, code;
  logic [3:0]  cas_bank_q, cas_bank_d;
  logic [14:0] cas_row_q, cas_row_d;
  logic [3:0]  bank;
  logic        tgt_open;
`ifdef DDR_PREA_EN
  logic        prea_blocked;
`endif

  assign bank     = {bus.bg_addr, bus.ba_addr};
  assign tgt_open = (state_q[bank] == BANK_ACTIVATING) || (state_q[bank] == BANK_ACTIVE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ras_d      = ras_q;
    row_d      = row_q;
    rrd_d      = (rrd_q == 6'd63) ? rrd_q : rrd_q + 6'd1;
    ack_d      = 1'b0;
    viol_d     = 1'b0;
    code_d     = 3'd0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    cas_bank_d = 4'd0;
    cas_row_d  = 15'd0;
    code       = 3'd0;
`ifdef DDR_PREA_EN
    prea_blocked = 1'b0;
`endif
    // Free-running timers first; a command to a bank below overrides its update.
    for (int b = 0; b < 16; b++) begin
      if (cnt_q[b] != 6'd0) cnt_d[b] = cnt_q[b] - 6'd1;
      if (ras_q[b] != 6'd0) ras_d[b] = ras_q[b] - 6'd1;
      if (state_q[b] == BANK_ACTIVATING  && cnt_q[b] == 6'd0) state_d[b] = BANK_ACTIVE;
      if (state_q[b] == BANK_PRECHARGING && cnt_q[b] == 6'd0) state_d[b] = BANK_IDLE;
    end
    if (bus.cmd_valid) begin
      case (bus.cmd)
        CMD_NOP: ;
        CMD_ACT: begin
          if (rrd_q < RRD_MIN) code = 3'd1;
          else if (state_q[bank] == BANK_PRECHARGING && cnt_q[bank] != 6'd0) code = 3'd2;
          else if (tgt_open) code = 3'd3;
          else begin
            state_d[bank] = BANK_ACTIVATING;
            cnt_d[bank]   = RCD_LOAD;
            ras_d[bank]   = RAS_LOAD;
            row_d[bank]   = bus.row_addr;
            rrd_d         = 6'd1;
          end
        end
        CMD_RD, CMD_WR: begin
          if (state_q[bank] == BANK_ACTIVATING && cnt_q[bank] != 6'd0) code = 3'd4;
          else if (!tgt_open) code = 3'd5;
          else begin
            rd_d       = (bus.cmd == CMD_RD);
            wr_d       = (bus.cmd == CMD_WR);
            cas_bank_d = bank;
            cas_row_d  = row_q[bank];
          end
        end
        CMD_PRE: begin
          // PRE to a closed bank is a harmless NOP and leaves its tRP timer running.
          if (tgt_open) begin
            if (ras_q[bank] != 6'd0) code = 3'd6;
            else begin
              state_d[bank] = BANK_PRECHARGING;
              cnt_d[bank]   = RP_LOAD;
            end
          end
        end
`ifdef DDR_PREA_EN
        CMD_PREA: begin
          for (int b = 0; b < 16; b++)
            if ((state_q[b] == BANK_ACTIVATING || state_q[b] == BANK_ACTIVE) && ras_q[b] != 6'd0)
              prea_blocked = 1'b1;
          if (prea_blocked) code = 3'd6;
          else begin
            for (int b = 0; b < 16; b++)
              if (state_q[b] == BANK_ACTIVATING || state_q[b] == BANK_ACTIVE) begin
                state_d[b] = BANK_PRECHARGING;
                cnt_d[b]   = RP_LOAD;
              end
          end
        end
`endif
        default: code = 3'd7;
      endcase
      // A rejected command must not disturb any bank or the tRRD reference.
      if (code != 3'd0) begin
        state_d = state_q;
        row_d   = row_q;
        for (int b = 0; b < 16; b++) begin
          cnt_d[b] = (cnt_q[b] != 6'd0) ? cnt_q[b] - 6'd1 : 6'd0;
          ras_d[b] = (ras_q[b] != 6'd0) ? ras_q[b] - 6'd1 : 6'd0;
          if (state_q[b] == BANK_ACTIVATING  && cnt_q[b] == 6'd0) state_d[b] = BANK_ACTIVE;
          if (state_q[b] == BANK_PRECHARGING && cnt_q[b] == 6'd0) state_d[b] = BANK_IDLE;
        end
        rrd_d = (rrd_q == 6'd63) ? rrd_q : rrd_q + 6'd1;
      end
      ack_d  = (code == 3'd0);
      viol_d = (code != 3'd0);
      code_d = code;
    end
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_q    <= '{default: BANK_IDLE};
      cnt_q      <= '{default: '0};
      ras_q      <= '{default: '0};
      row_q      <= '{default: '0};
      rrd_q      <= 6'd63;
      ack_q      <= 1'b0;
      viol_q     <= 1'b0;
      code_q     <= 3'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cas_bank_q <= 4'd0;
      cas_row_q  <= 15'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ras_q      <= ras_d;
      row_q      <= row_d;
      rrd_q      <= rrd_d;
      ack_q      <= ack_d;
      viol_q     <= viol_d;
      code_q     <= code_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cas_bank_q <= cas_bank_d;
      cas_row_q  <= cas_row_d;
    end
  end

  always_comb begin
    for (int b = 0; b < 16; b++) begin
      bus.bank_open[b]             = (state_q[b] == BANK_ACTIVATING) || (state_q[b] == BANK_ACTIVE);
      bus.dbg_bank_state[2*b +: 2] = state_q[b];
    end
  end

  assign bus.cmd_ack   = ack_q;
  assign bus.viol      = viol_q;
  assign bus.viol_code = code_q;
  assign bus.rd_go     = rd_q;
  assign bus.wr_go     = wr_q;
  assign bus.cas_bank  = cas_bank_q;
  assign bus.cas_row   = cas_row_q;
endmodule

// File: tb/tb_ddr_bank_responder.sv
// Directed bench for ddr_bank_responder: driver pushes hand-computed responses, negedge monitor compares.
module tb_ddr_bank_responder;
  localparam int W = 42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   resp_idx = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_got;

  ddr_bank_responder_if bus();
  ddr_bank_responder dut (.CK_t(clk), .reset(rst), .bus(bus));

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] got_word();
    return {bus.cmd_ack, bus.viol, bus.viol_code, bus.rd_go, bus.wr_go,
            bus.cas_bank, bus.cas_row, bus.bank_open};
  endfunction

  // driver tasks: each occupies exactly one sampling edge per cycle
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd       = 3'd0;
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] b, input logic [14:0] r,
                      input logic [2:0] code, input logic [14:0] row_exp, input logic [15:0] open_exp);
    logic go;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.bg_addr   = b[3:2];
    bus.ba_addr   = b[1:0];
    bus.row_addr  = r;
    go = (code == 3'd0) && (c == 3'd3 || c == 3'd4);
    exp_q.push_back({code == 3'd0, code != 3'd0, code, go && (c == 3'd3), go && (c == 3'd4),
                     go ? b : 4'd0, go ? row_exp : 15'd0, open_exp});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    rst           = 1'b1;
    repeat (n) @(negedge clk);
    checks++;
    if ({got_word(), bus.dbg_bank_state} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", {got_word(), bus.dbg_bank_state});
    end
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.cmd_ack || bus.viol) begin
      checks++;
      mon_got = got_word();
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected #%0d: got %h required none", resp_idx, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL resp #%0d: got %h required %h", resp_idx, mon_got, mon_exp);
        end
      end
      resp_idx++;
    end
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.bg_addr   = 2'd0;
    bus.ba_addr   = 2'd0;
    bus.row_addr  = 15'd0;
    do_reset(3);

    // ACT then RD exactly at tRCD
    send(3'd1, 4'd0, 15'h123, 3'd0, 15'h0,   16'h0001);
    idle(15);
    send(3'd3, 4'd0, 15'h0,   3'd0, 15'h123, 16'h0001);

    // tRRD: too early, then retry exactly at tRRD
    send(3'd1, 4'd6, 15'h010, 3'd0, 15'h0, 16'h0041);
    idle(1);
    send(3'd1, 4'd5, 15'h020, 3'd1, 15'h0, 16'h0041);
    idle(1);
    send(3'd1, 4'd5, 15'h020, 3'd0, 15'h0, 16'h0061);

    // tRCD boundary: one cycle short, then WR at tRCD
    idle(3);
    send(3'd1, 4'd3, 15'h2AB, 3'd0, 15'h0,   16'h0069);
    idle(14);
    send(3'd3, 4'd3, 15'h0,   3'd4, 15'h0,   16'h0069);
    send(3'd4, 4'd3, 15'h0,   3'd0, 15'h2AB, 16'h0069);

    // tRAS and tRP boundaries on bank 2
    send(3'd1, 4'd2, 15'h055, 3'd0, 15'h0, 16'h006D);
    idle(37);
    send(3'd2, 4'd2, 15'h0,   3'd6, 15'h0, 16'h006D);
    send(3'd2, 4'd2, 15'h0,   3'd0, 15'h0, 16'h0069);
    idle(14);
    send(3'd1, 4'd2, 15'h056, 3'd2, 15'h0, 16'h0069);
    send(3'd1, 4'd2, 15'h056, 3'd0, 15'h0, 16'h006D);

    // closed-bank access, PRE to idle, ACT to open bank, reserved opcode, NOP
    send(3'd3, 4'd9, 15'h0, 3'd5, 15'h0, 16'h006D);
    send(3'd2, 4'd9, 15'h0, 3'd0, 15'h0, 16'h006D);
    idle(1);
    send(3'd1, 4'd0, 15'h0, 3'd3, 15'h0, 16'h006D);
    send(3'd4, 4'd9, 15'h0, 3'd5, 15'h0, 16'h006D);
    send(3'd6, 4'd0, 15'h0, 3'd7, 15'h0, 16'h006D);
    send(3'd0, 4'd0, 15'h0, 3'd0, 15'h0, 16'h006D);

    // reset while bank 1 precharges, then ACT b1 immediately
    idle(3);
    send(3'd1, 4'd1, 15'h7FFF, 3'd0, 15'h0, 16'h006F);
    idle(38);
    send(3'd2, 4'd1, 15'h0,    3'd0, 15'h0, 16'h006D);
    do_reset(1);
    send(3'd1, 4'd1, 15'h011,  3'd0, 15'h0, 16'h0002);

    // precharge-all: blocked by tRAS, then after tRAS
    idle(3);
    send(3'd1, 4'd0, 15'h031, 3'd0, 15'h0, 16'h0003);
    idle(3);
    send(3'd1, 4'd4, 15'h032, 3'd0, 15'h0, 16'h0013);
`ifdef DDR_PREA_EN
    send(3'd5, 4'd0, 15'h0, 3'd6, 15'h0, 16'h0013);
    idle(37);
    send(3'd5, 4'd0, 15'h0, 3'd0, 15'h0, 16'h0000);
`else
    send(3'd5, 4'd0, 15'h0, 3'd7, 15'h0, 16'h0013);
    idle(37);
    send(3'd5, 4'd0, 15'h0, 3'd7, 15'h0, 16'h0013);
`endif
    send(3'd7, 4'd0, 15'h0, 3'd7, 15'h0, 16'h0013 & {16{1'b1}} & (
`ifdef DDR_PREA_EN
      16'h0000
`else
      16'h0013
`endif
    ));

    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
